// File: rtl/button_frontend.sv
// Per-channel push-button conditioner: two-flop synchronizer, debounce filter,
// press/release edge pulses and an auto-repeat "held" pulse generator.
module button_frontend #(
  parameter int NBTN          = 4,
  parameter int DB_CYCLES     = 16,
  parameter int HOLD_CYCLES   = 64,
  parameter int REPEAT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic [NBTN-1:0] raw_btn,
  output logic [NBTN-1:0] level,
  output logic [NBTN-1:0] pressed,
  output logic [NBTN-1:0] released,
  output logic [NBTN-1:0] held
);

  localparam int DBC_W  = $clog2(DB_CYCLES + 1);
  localparam int HC_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HC_W   = $clog2(HC_MAX + 1);

  localparam logic [DBC_W-1:0] DB_LAST   = DBC_W'(DB_CYCLES - 1);
  localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
  localparam logic [HC_W-1:0]  REP_LAST  = HC_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_HOLD,
    REPEAT
  } hold_state_t;

  genvar i;
  generate
    for (i = 0; i < NBTN; i++) begin : g_ch
      logic             s1;
      logic             s2;
      logic [DBC_W-1:0] dbc;
      logic [DBC_W-1:0] dbc_nxt;
      logic             lvl;
      logic             lvl_nxt;
      logic             prs;
      logic             rls;
      logic             hld;
      logic             hld_nxt;
      hold_state_t      st;
      hold_state_t      st_nxt;
      logic [HC_W-1:0]  hc;
      logic [HC_W-1:0]  hc_nxt;

      // Debounce: accept s2 only after DB_CYCLES consecutive disagreeing cycles.
      always_comb begin
        lvl_nxt = lvl;
        dbc_nxt = '0;
        if (s2 != lvl) begin
          if (dbc == DB_LAST) begin
            lvl_nxt = s2;
          end else begin
            dbc_nxt = dbc + 1'b1;
          end
        end
      end

      // Hold FSM runs off the level being registered this cycle, so a release
      // landing on a terminal count suppresses that held pulse.
      always_comb begin
        st_nxt  = st;
        hc_nxt  = hc;
        hld_nxt = 1'b0;
        if (!lvl_nxt) begin
          st_nxt = IDLE;
          hc_nxt = '0;
        end else begin
          case (st)
            IDLE: begin
              st_nxt = WAIT_HOLD;
              hc_nxt = '0;
            end
            WAIT_HOLD: begin
              if (hc == HOLD_LAST) begin
                hld_nxt = 1'b1;
                hc_nxt  = '0;
                st_nxt  = REPEAT;
              end else begin
                hc_nxt = hc + 1'b1;
              end
            end
            REPEAT: begin
              if (hc == REP_LAST) begin
                hld_nxt = 1'b1;
                hc_nxt  = '0;
              end else begin
                hc_nxt = hc + 1'b1;
              end
            end
            default: begin
              st_nxt = IDLE;
              hc_nxt = '0;
            end
          endcase
        end
      end

      always_ff @(posedge clk) begin
        if (n_rst) begin
          s1  <= 1'b0;
          s2  <= 1'b0;
          dbc <= '0;
          lvl <= 1'b0;
          prs <= 1'b0;
          rls <= 1'b0;
          hld <= 1'b0;
          st  <= IDLE;
          hc  <= '0;
        end else begin
          s1  <= raw_btn[i];
          s2  <= s1;
          dbc <= dbc_nxt;
          lvl <= lvl_nxt;
          prs <= lvl_nxt & ~lvl;
          rls <= ~lvl_nxt & lvl;
          hld <= hld_nxt;
          st  <= st_nxt;
          hc  <= hc_nxt;
        end
      end

      assign level[i]    = lvl;
      assign pressed[i]  = prs;
      assign released[i] = rls;
      assign held[i]     = hld;
    end
  endgenerate

endmodule

// File: tb/tb_button_frontend.sv
// Bench for button_frontend: directed scenarios plus random button activity,
// compared every cycle against a sliding-window behavioural model.
module tb_button_frontend;
  localparam int NBTN = 4;
  localparam int DB   = 16;
  localparam int HOLD = 64;
  localparam int REP  = 16;
  localparam logic [31:0] WIN = (32'd1 << DB) - 32'd1;

  logic            clk = 1'b0;
  logic            n_rst;
  logic [NBTN-1:0] raw_btn;
  logic [NBTN-1:0] level;
  logic [NBTN-1:0] pressed;
  logic [NBTN-1:0] released;
  logic [NBTN-1:0] held;

  int tests_run    = 0;
  int tests_failed = 0;

  button_frontend #(
    .NBTN(NBTN), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .n_rst(n_rst), .raw_btn(raw_btn),
    .level(level), .pressed(pressed), .released(released), .held(held)
  );

  always #5 clk = ~clk;

  // Reference model state: raw delayed two cycles, a history of synchronized
  // samples, and the number of cycles since the last accepted press.
  logic [NBTN-1:0] m_s1, m_s2, m_level, m_pressed, m_released, m_held;
  logic [31:0]     m_hist [NBTN];
  int              m_age  [NBTN];

  task automatic tick();
    logic nl;
    @(posedge clk);
    if (n_rst) begin
      m_s1 = '0; m_s2 = '0; m_level = '0;
      m_pressed = '0; m_released = '0; m_held = '0;
      for (int c = 0; c < NBTN; c++) begin
        m_hist[c] = '0;
        m_age[c]  = 0;
      end
    end else begin
      for (int c = 0; c < NBTN; c++) begin
        m_hist[c] = {m_hist[c][30:0], m_s2[c]};
        nl = m_level[c];
        if (!m_level[c] && ((m_hist[c] & WIN) == WIN)) nl = 1'b1;
        else if (m_level[c] && ((m_hist[c] & WIN) == 32'd0)) nl = 1'b0;
        m_pressed[c]  = nl & ~m_level[c];
        m_released[c] = ~nl & m_level[c];
        if (m_pressed[c]) m_age[c] = 0;
        else if (nl) m_age[c] = m_age[c] + 1;
        m_held[c] = nl && !m_pressed[c] && (m_age[c] >= HOLD) &&
                    (((m_age[c] - HOLD) % REP) == 0);
        m_level[c] = nl;
      end
      m_s2 = m_s1;
      m_s1 = raw_btn;
    end
    #1;
  endtask

  task automatic reset_dut();
    n_rst   = 1'b1;
    raw_btn = '0;
    tick();
    tick();
    n_rst = 1'b0;
  endtask

  task automatic test_reset();
    n_rst   = 1'b1;
    raw_btn = 4'($urandom);
    tick();
    raw_btn = '1;
    for (int n = 0; n < 3; n++) begin
      tick();
      tests_run++;
      if ({level, pressed, released, held} !== 16'h0) begin
        tests_failed++;
        $display("FAIL reset_state t=%0d got lvl/prs/rls/hld=%b/%b/%b/%b want all 0",
                 n, level, pressed, released, held);
      end
    end
    n_rst = 1'b0;
  endtask

  task automatic test_clean_press();
    int prs_cnt = 0;
    int prs_idx = -1;
    int hq[$];
    reset_dut();
    raw_btn = 4'b0001;
    for (int n = 0; n < 200; n++) begin
      tick();
      tests_run++;
      if ({level, pressed, released, held} !== {m_level, m_pressed, m_released, m_held}) begin
        tests_failed++;
        $display("FAIL clean_press_model t=%0d got lvl/prs/rls/hld=%b/%b/%b/%b want %b/%b/%b/%b",
                 n, level, pressed, released, held, m_level, m_pressed, m_released, m_held);
      end
      if (pressed[0]) begin
        prs_cnt++;
        if (prs_idx < 0) prs_idx = n;
      end
      if (held[0]) hq.push_back(n);
    end
    tests_run++;
    if (prs_cnt != 1 || prs_idx != 1 + DB) begin
      tests_failed++;
      $display("FAIL clean_press_latency got count=%0d edge=%0d want count=1 edge=%0d",
               prs_cnt, prs_idx, 1 + DB);
    end
    tests_run++;
    if (hq.size() != 8) begin
      tests_failed++;
      $display("FAIL clean_press_held_count got %0d want 8", hq.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if (hq[k] != 1 + DB + HOLD + k * REP) begin
          tests_failed++;
          $display("FAIL clean_press_held_edge k=%0d got %0d want %0d",
                   k, hq[k], 1 + DB + HOLD + k * REP);
        end
      end
    end
  endtask

  task automatic test_bounce();
    logic [NBTN-1:0] seen = '0;
    reset_dut();
    for (int n = 0; n < 140; n++) begin
      raw_btn = (n < 100 && ((n / 5) % 2) == 0) ? 4'b0010 : 4'b0000;
      tick();
      tests_run++;
      if ({level, pressed, released, held} !== {m_level, m_pressed, m_released, m_held}) begin
        tests_failed++;
        $display("FAIL bounce_model t=%0d got lvl/prs/rls/hld=%b/%b/%b/%b want %b/%b/%b/%b",
                 n, level, pressed, released, held, m_level, m_pressed, m_released, m_held);
      end
      seen = seen | level | pressed | released | held;
    end
    tests_run++;
    if (seen !== 4'b0000) begin
      tests_failed++;
      $display("FAIL bounce_quiet got activity=%b want 0000", seen);
    end
  endtask

  task automatic test_bounce_settle();
    int prs_cnt = 0;
    int prs_idx = -1;
    reset_dut();
    for (int n = 0; n < 86; n++) begin
      raw_btn = (n >= 36 || ((n / 6) % 2) == 0) ? 4'b0100 : 4'b0000;
      tick();
      tests_run++;
      if ({level, pressed, released, held} !== {m_level, m_pressed, m_released, m_held}) begin
        tests_failed++;
        $display("FAIL settle_model t=%0d got lvl/prs/rls/hld=%b/%b/%b/%b want %b/%b/%b/%b",
                 n, level, pressed, released, held, m_level, m_pressed, m_released, m_held);
      end
      if (pressed[2]) begin
        prs_cnt++;
        prs_idx = n;
      end
    end
    tests_run++;
    if (prs_cnt != 1 || prs_idx != 36 + 1 + DB) begin
      tests_failed++;
      $display("FAIL settle_press got count=%0d edge=%0d want count=1 edge=%0d",
               prs_cnt, prs_idx, 36 + 1 + DB);
    end
  endtask

  task automatic test_release();
    int rls_cnt = 0;
    int rls_idx = -1;
    int hld_cnt = 0;
    reset_dut();
    for (int n = 0; n < 87; n++) begin
      raw_btn = (n < 47) ? 4'b1000 : 4'b0000;
      tick();
      tests_run++;
      if ({level, pressed, released, held} !== {m_level, m_pressed, m_released, m_held}) begin
        tests_failed++;
        $display("FAIL release_model t=%0d got lvl/prs/rls/hld=%b/%b/%b/%b want %b/%b/%b/%b",
                 n, level, pressed, released, held, m_level, m_pressed, m_released, m_held);
      end
      if (released[3]) begin
        rls_cnt++;
        rls_idx = n;
      end
      if (held[3]) hld_cnt++;
    end
    tests_run++;
    if (rls_cnt != 1 || rls_idx != 47 + 1 + DB) begin
      tests_failed++;
      $display("FAIL release_pulse got count=%0d edge=%0d want count=1 edge=%0d",
               rls_cnt, rls_idx, 47 + 1 + DB);
    end
    tests_run++;
    if (hld_cnt != 0 || level[3] !== 1'b0) begin
      tests_failed++;
      $display("FAIL release_no_held got held=%0d level=%b want held=0 level=0",
               hld_cnt, level[3]);
    end
  endtask

  task automatic test_simultaneous();
    logic [NBTN-1:0] first = '0;
    int idx = -1;
    reset_dut();
    raw_btn = 4'b1011;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (idx < 0 && pressed != 4'b0000) begin
        idx   = n;
        first = pressed;
      end
    end
    tests_run++;
    if (first !== 4'b1011 || idx != 1 + DB) begin
      tests_failed++;
      $display("FAIL simultaneous got pressed=%b edge=%0d want 1011 edge=%0d",
               first, idx, 1 + DB);
    end
  endtask

  task automatic test_reset_mid_hold();
    int prs_idx = -1;
    reset_dut();
    raw_btn = 4'b0001;
    for (int n = 0; n < 120; n++) begin
      tick();
      tests_run++;
      if ({level, pressed, released, held} !== {m_level, m_pressed, m_released, m_held}) begin
        tests_failed++;
        $display("FAIL midhold_model t=%0d got lvl/prs/rls/hld=%b/%b/%b/%b want %b/%b/%b/%b",
                 n, level, pressed, released, held, m_level, m_pressed, m_released, m_held);
      end
    end
    n_rst = 1'b1;
    tick();
    tests_run++;
    if ({level, pressed, released, held} !== 16'h0) begin
      tests_failed++;
      $display("FAIL midhold_reset got lvl/prs/rls/hld=%b/%b/%b/%b want all 0",
               level, pressed, released, held);
    end
    n_rst = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      tests_run++;
      if ({level, pressed, released, held} !== {m_level, m_pressed, m_released, m_held}) begin
        tests_failed++;
        $display("FAIL midhold_after t=%0d got lvl/prs/rls/hld=%b/%b/%b/%b want %b/%b/%b/%b",
                 n, level, pressed, released, held, m_level, m_pressed, m_released, m_held);
      end
      if (pressed[0] && prs_idx < 0) prs_idx = n;
    end
    tests_run++;
    if (prs_idx != 1 + DB) begin
      tests_failed++;
      $display("FAIL midhold_repress got edge=%0d want %0d", prs_idx, 1 + DB);
    end
  endtask

  task automatic test_random();
    reset_dut();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 24) == 0) raw_btn[$urandom_range(0, NBTN - 1)] ^= 1'b1;
      n_rst = ($urandom_range(0, 599) == 0);
      tick();
      tests_run++;
      if ({level, pressed, released, held} !== {m_level, m_pressed, m_released, m_held}) begin
        tests_failed++;
        if (tests_failed < 20)
          $display("FAIL random_model t=%0d got lvl/prs/rls/hld=%b/%b/%b/%b want %b/%b/%b/%b",
                   n, level, pressed, released, held, m_level, m_pressed, m_released, m_held);
      end
    end
    n_rst = 1'b0;
  endtask

  initial begin
    n_rst   = 1'b1;
    raw_btn = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_bounce_settle();
    test_release();
    test_simultaneous();
    test_reset_mid_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
